// File: rtl/cheat_pkg.sv
package cheat_pkg;

  localparam int unsigned MAX_SLOTS = 64;
  localparam int unsigned SLOT_IW   = 6;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_REMOVE = 2'd1,
    OP_TOGGLE = 2'd2,
    OP_CLEAR  = 2'd3
  } cheat_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_WRITE,
    S_CLEAR
  } cheat_state_e;

  typedef struct packed {
    logic               found;
    logic [SLOT_IW-1:0] idx;
  } cheat_pick_t;

  // Shared by the bus matcher and the SEARCH key lookup.
  function automatic cheat_pick_t pick_lowest(input logic [MAX_SLOTS-1:0] mask);
    cheat_pick_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      if (mask[i] && !r.found) begin
        r.found = 1'b1;
        r.idx   = SLOT_IW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cheat_match.sv
module cheat_match
  import cheat_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_CODES  = 8
) (
  input  logic                  enable_i,
  input  logic [MAX_CODES-1:0]  slot_valid_i,
  input  logic [MAX_CODES-1:0]  slot_en_i,
  input  logic [MAX_CODES-1:0]  slot_cmp_en_i,
  input  logic [ADDR_WIDTH-1:0] slot_addr_i    [MAX_CODES],
  input  logic [DATA_WIDTH-1:0] slot_compare_i [MAX_CODES],
  input  logic [DATA_WIDTH-1:0] slot_data_i    [MAX_CODES],
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ovr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [MAX_SLOTS-1:0] qual;
  cheat_pick_t          pick;

  always_comb begin
    qual = '0;
    for (int unsigned i = 0; i < MAX_CODES; i++) begin
      qual[i] = enable_i && slot_valid_i[i] && slot_en_i[i] &&
                (slot_addr_i[i] == addr_i) &&
                (!slot_cmp_en_i[i] || (slot_compare_i[i] == data_i));
    end
    pick   = pick_lowest(qual);
    ovr_o  = pick.found;
    data_o = '0;
    for (int unsigned i = 0; i < MAX_CODES; i++) begin
      if (pick.found && (pick.idx == SLOT_IW'(i))) data_o = slot_data_i[i];
    end
  end

endmodule

// File: rtl/cheat_engine.sv
module cheat_engine
  import cheat_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_CODES  = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_compare,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic                             cmd_cmp_en,
  input  logic                             cmd_enable,
  output logic                             resp_valid,
  output logic                             resp_err,
  input  logic [ADDR_WIDTH-1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             genie_ovr,
  output logic [DATA_WIDTH-1:0]            genie_data,
  output logic [$clog2(MAX_CODES+1)-1:0]   count,
  output logic                             available
);

  localparam int unsigned IW = $clog2(MAX_CODES);
  localparam int unsigned CW = $clog2(MAX_CODES + 1);

  logic [MAX_CODES-1:0]  valid_q, en_q, cmp_en_q;
  logic [ADDR_WIDTH-1:0] addr_q    [MAX_CODES];
  logic [DATA_WIDTH-1:0] compare_q [MAX_CODES];
  logic [DATA_WIDTH-1:0] data_q    [MAX_CODES];

  cheat_state_e          state_q;
  cheat_op_e             op_q;
  logic [ADDR_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] cmd_cmp_q, cmd_data_q;
  logic                  cmd_cmp_en_q, cmd_en_q;
  logic                  hit_q, full_q;
  logic [IW-1:0]         hit_idx_q, free_idx_q, sweep_q;
  logic                  resp_valid_q, resp_err_q;
  logic [CW-1:0]         count_q;

  logic [MAX_SLOTS-1:0]  hit_mask, free_mask;
  cheat_pick_t           hit_pick, free_pick;
  logic [IW-1:0]         widx;

  always_comb begin
    hit_mask  = '0;
    free_mask = '0;
    for (int unsigned i = 0; i < MAX_CODES; i++) begin
      hit_mask[i]  = valid_q[i] && (addr_q[i] == key_q);
      free_mask[i] = !valid_q[i];
    end
    hit_pick  = pick_lowest(hit_mask);
    free_pick = pick_lowest(free_mask);
  end

  assign widx = hit_q ? hit_idx_q : free_idx_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      en_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      count_q      <= '0;
      sweep_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cheat_op_e'(cmd_op);
            key_q        <= cmd_addr;
            cmd_cmp_q    <= cmd_compare;
            cmd_data_q   <= cmd_data;
            cmd_cmp_en_q <= cmd_cmp_en;
            cmd_en_q     <= cmd_enable;
            if (cmd_op == OP_CLEAR) begin
              state_q <= S_CLEAR;
              sweep_q <= '0;
            end else begin
              state_q <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          hit_q      <= hit_pick.found;
          hit_idx_q  <= IW'(hit_pick.idx);
          free_idx_q <= IW'(free_pick.idx);
          full_q     <= !free_pick.found;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          state_q      <= S_IDLE;
          case (op_q)
            OP_ADD: begin
              if (hit_q || !full_q) begin
                valid_q[widx]   <= 1'b1;
                en_q[widx]      <= cmd_en_q;
                cmp_en_q[widx]  <= cmd_cmp_en_q;
                addr_q[widx]    <= key_q;
                compare_q[widx] <= cmd_cmp_q;
                data_q[widx]    <= cmd_data_q;
              end
              if (!hit_q) begin
                if (full_q) resp_err_q <= 1'b1;
                else        count_q    <= count_q + CW'(1);
              end
            end
            OP_REMOVE: begin
              if (hit_q) begin
                valid_q[hit_idx_q] <= 1'b0;
                count_q            <= count_q - CW'(1);
              end else begin
                resp_err_q <= 1'b1;
              end
            end
            OP_TOGGLE: begin
              if (hit_q) en_q[hit_idx_q] <= !en_q[hit_idx_q];
              else       resp_err_q      <= 1'b1;
            end
            default: ;
          endcase
        end
        S_CLEAR: begin
          valid_q[sweep_q] <= 1'b0;
          if (sweep_q == IW'(MAX_CODES - 1)) begin
            count_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            sweep_q <= sweep_q + IW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign count      = count_q;
  assign available  = |(valid_q & en_q);

  cheat_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_CODES  (MAX_CODES)
  ) u_match (
    .enable_i       (enable),
    .slot_valid_i   (valid_q),
    .slot_en_i      (en_q),
    .slot_cmp_en_i  (cmp_en_q),
    .slot_addr_i    (addr_q),
    .slot_compare_i (compare_q),
    .slot_data_i    (data_q),
    .addr_i         (addr_in),
    .data_i         (data_in),
    .ovr_o          (genie_ovr),
    .data_o         (genie_data)
  );

endmodule

// File: tb/tb_cheat_engine.sv
module tb_cheat_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_compare = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_cmp_en = 1'b0;
  logic        cmd_enable = 1'b0;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic        genie_ovr;
  logic [7:0]  genie_data;
  logic [3:0]  count;
  logic        available;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cheat_engine #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .MAX_CODES  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_compare (cmd_compare),
    .cmd_data    (cmd_data),
    .cmd_cmp_en  (cmd_cmp_en),
    .cmd_enable  (cmd_enable),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .genie_ovr   (genie_ovr),
    .genie_data  (genie_data),
    .count       (count),
    .available   (available)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [7:0] cmpv, input logic [7:0] d, input logic ce,
                         input logic en, input logic exp_err, input int exp_lat);
    int lat;
    int rdy_seen;
    logic got_resp;
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_op      = op;
    cmd_addr    = a;
    cmd_compare = cmpv;
    cmd_data    = d;
    cmd_cmp_en  = ce;
    cmd_enable  = en;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    rdy_seen = 0;
    got_resp = 1'b0;
    while (lat < 64 && !got_resp) begin
      @(posedge clk);
      #1 lat++;
      if (resp_valid) begin
        got_resp = 1'b1;
        check_eq({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      end else if (cmd_ready) begin
        rdy_seen++;
      end
    end
    if (!got_resp) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    check_eq({tag, "_busy"}, 32'(rdy_seen), 32'd0);
  endtask

  task automatic probe(input string tag, input logic [15:0] a, input logic [7:0] dv,
                       input logic en_in, input logic exp_ovr, input logic [7:0] exp_data);
    @(negedge clk);
    addr_in = a;
    data_in = dv;
    enable  = en_in;
    #1;
    check_eq({tag, "_ovr"},  32'(genie_ovr),  32'(exp_ovr));
    check_eq({tag, "_data"}, 32'(genie_data), 32'(exp_data));
  endtask

  initial begin
    int resp_seen;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_resp",  32'(resp_valid), 32'd0);
    check_eq("rst_err",   32'(resp_err), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_avail", 32'(available), 32'd0);
    check_eq("rst_ovr",   32'(genie_ovr), 32'd0);
    check_eq("rst_gdata", 32'(genie_data), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Slot 0: unconditional 0x1234 -> 0x5A.
    run_cmd("add1234", 2'd0, 16'h1234, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 2);
    check_eq("add1234_count", 32'(count), 32'd1);
    check_eq("add1234_avail", 32'(available), 32'd1);
    probe("m1234", 16'h1234, 8'h00, 1'b1, 1'b1, 8'h5A);
    probe("m1235", 16'h1235, 8'h00, 1'b1, 1'b0, 8'h00);

    // Slot 1: compare-qualified 0x2000 (0x11 -> 0x22).
    run_cmd("add2000", 2'd0, 16'h2000, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0, 2);
    probe("cmp_hit",  16'h2000, 8'h11, 1'b1, 1'b1, 8'h22);
    probe("cmp_miss", 16'h2000, 8'h12, 1'b1, 1'b0, 8'h00);
    probe("glob_off", 16'h2000, 8'h11, 1'b0, 1'b0, 8'h00);

    // Slots 2..7: 0x3000..0x3005, so slot 3 holds 0x3001.
    for (int i = 0; i < 6; i++)
      run_cmd("fill", 2'd0, 16'h3000 + 16'(i), 8'h00, 8'h30 + 8'(i), 1'b0, 1'b1, 1'b0, 2);
    check_eq("full_count", 32'(count), 32'd8);
    probe("m3005", 16'h3005, 8'h00, 1'b1, 1'b1, 8'h35);
    run_cmd("add_full", 2'd0, 16'h4000, 8'h00, 8'h44, 1'b0, 1'b1, 1'b1, 2);
    check_eq("add_full_count", 32'(count), 32'd8);
    probe("m4000", 16'h4000, 8'h00, 1'b1, 1'b0, 8'h00);
    run_cmd("overwrite", 2'd0, 16'h1234, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 2);
    check_eq("overwrite_count", 32'(count), 32'd8);
    probe("m1234_new", 16'h1234, 8'h00, 1'b1, 1'b1, 8'h77);

    run_cmd("rm3001", 2'd1, 16'h3001, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    check_eq("rm_count", 32'(count), 32'd7);
    probe("m3001_gone", 16'h3001, 8'h00, 1'b1, 1'b0, 8'h00);
    run_cmd("reuse", 2'd0, 16'h5000, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0, 2);
    check_eq("reuse_count", 32'(count), 32'd8);
    probe("m5000", 16'h5000, 8'h00, 1'b1, 1'b1, 8'h99);
    run_cmd("add_full2", 2'd0, 16'h6001, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 2);
    run_cmd("rm_unknown", 2'd1, 16'h6000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    check_eq("rm_unknown_count", 32'(count), 32'd8);

    run_cmd("tog_off", 2'd2, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    probe("tog_off_m", 16'h1234, 8'h00, 1'b1, 1'b0, 8'h00);
    check_eq("tog_off_avail", 32'(available), 32'd1);
    run_cmd("tog_on", 2'd2, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    probe("tog_on_m", 16'h1234, 8'h00, 1'b1, 1'b1, 8'h77);
    run_cmd("tog_unknown", 2'd2, 16'h7777, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2);

    run_cmd("clear", 2'd3, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8);
    check_eq("clear_count", 32'(count), 32'd0);
    check_eq("clear_avail", 32'(available), 32'd0);
    probe("clear_m1234", 16'h1234, 8'h00, 1'b1, 1'b0, 8'h00);
    probe("clear_m2000", 16'h2000, 8'h11, 1'b1, 1'b0, 8'h00);

    // Sole enabled entry: toggling it drops available.
    run_cmd("solo_add", 2'd0, 16'h1234, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 2);
    run_cmd("solo_tog", 2'd2, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    check_eq("solo_avail_off", 32'(available), 32'd0);
    check_eq("solo_count", 32'(count), 32'd1);
    run_cmd("solo_tog2", 2'd2, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    check_eq("solo_avail_on", 32'(available), 32'd1);
    run_cmd("add2000b", 2'd0, 16'h2000, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0, 2);

    // CLEAR interrupted by reset after slot 0 has been swept.
    @(negedge clk);
    cmd_op    = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 addr_in = 16'h1234;
    data_in = 8'h00;
    enable  = 1'b1;
    #1 check_eq("midclr_slot0", 32'(genie_ovr), 32'd0);
    addr_in = 16'h2000;
    data_in = 8'h11;
    #1 check_eq("midclr_slot1", 32'(genie_ovr), 32'd1);
    check_eq("midclr_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstclr_count", 32'(count), 32'd0);
    check_eq("rstclr_ready", 32'(cmd_ready), 32'd1);
    check_eq("rstclr_ovr",   32'(genie_ovr), 32'd0);
    check_eq("rstclr_avail", 32'(available), 32'd0);
    resp_seen = 0;
    if (resp_valid) resp_seen++;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (resp_valid) resp_seen++;
    end
    check_eq("rstclr_noresp", 32'(resp_seen), 32'd0);
    probe("rstclr_m2000", 16'h2000, 8'h11, 1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
